req_key_gen: RTL and testbench
==============================

Name: req_key_gen

Overview:
- Parametrised multi-channel request generator; successor to the single-channel always-requesting key counter.
- Each channel owns a free-running request key that advances only on an accepted handshake.
- A round-robin arbiter selects among enabled channels. Issue is throttled by an in-order outstanding-tracking FIFO.
- The FIFO checks returning responses against issued {channel, key} and flags mismatches. The block sits in the comb_loop/handshake verification environment as the stimulus-side requester.

Parameters:
- NUM_CH, 4, number of request channels (>=2); CH_W = $clog2(NUM_CH) derived.
- KEY_W, 4, per-channel key width; keys wrap modulo 2^KEY_W.
- DEPTH, 4, maximum outstanding (issued, unresponded) requests (>=1); CNT_W = $clog2(DEPTH+1) derived.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ch_en  in  NUM_CH  per-channel request enable.
- req  out  1  request valid (registered).
- req_ch  out  CH_W  channel of current request.
- req_key  out  KEY_W  key of current request.
- ack  in  1  request accepted when req && ack.
- rsp_valid  in  1  response strobe, one response per cycle, always accepted.
- rsp_ch  in  CH_W  channel of response.
- rsp_key  in  KEY_W  key of response.
- outstanding  out  CNT_W  tracking FIFO occupancy.
- err  out  1  sticky response-mismatch flag.

Behaviour:
- Reset (rst_n=0, async):
  - req=0, req_ch=0, req_key=0.
  - All channel keys=0, rr pointer=0, FIFO empty, outstanding=0, err=0.
- FSM has two states.
  - IDLE: req=0.
  - PEND: req=1, req_ch and req_key held stable.
- Launch condition, evaluated each cycle in IDLE, or in PEND on the ack cycle:
  - eligible = (ch_en != 0) && (count_next < DEPTH).
  - count_next = occupancy after this cycle's push and pop.
- Arbitration: the first channel with ch_en set, searching from the rr pointer upward with wrap. The winner's current key is registered into req_key and the winner into req_ch.
- Launch latency: req rises the cycle after the launch condition holds (one-cycle registered).
- Stability: in PEND, req, req_ch and req_key do not change until req && ack, even if ch_en[req_ch] drops.
- On req && ack:
  - Push {req_ch, req_key} into the FIFO.
  - Increment key[req_ch] (wrap 2^KEY_W-1 -> 0).
  - rr pointer <= req_ch+1 mod NUM_CH.
  - If the launch condition holds this same cycle, stay in PEND with the new selection (back-to-back, one request per cycle max). Otherwise go to IDLE.
- Back-to-back on one channel: if only that channel is enabled, the next request carries key+1 in the next cycle.
- Overflow: the FIFO cannot overflow, because launch reserves a slot and only one request is pending.
- On rsp_valid with FIFO non-empty:
  - Pop the head.
  - If {rsp_ch, rsp_key} != head, set err=1 (sticky until reset).
- On rsp_valid with FIFO empty: err=1, no pop, occupancy unchanged.
  - No bypass: a push in the same cycle does not satisfy a response.
- Simultaneous push and pop: occupancy unchanged; the FIFO read and write pointers wrap modulo DEPTH.
- outstanding reflects registered occupancy and is updated the cycle after push/pop.
- Reset mid-operation: everything returns to reset values immediately. A pending req is dropped and not retried.

Test Plan:
- Reset, ch_en=4'b0001, ack held 1 -> req rises the cycle after ch_en; req_ch=0, req_key = 0,1,2,3 on consecutive cycles. With no responses, req drops after 4 accepts and outstanding=4.
- ch_en=4'b1111, ack=1, responses echoing issued pairs one cycle later -> req_ch cycles 0,1,2,3,0. The key of each channel increments on its own visits only. err stays 0 and outstanding never exceeds 4.
- req pending on ch 2, ack held 0 for 5 cycles while ch_en[2] drops and ch_en[0] rises -> req_ch=2 and req_key stay unchanged for 5 cycles. After ack, the next request goes to ch 0 (rr from 3 wraps).
- 17 accepts on ch 1 with matching responses -> req_key sequence 0..15, then 0 (wrap). err=0.
- Response with rsp_key off by one from the FIFO head -> err=1 the next cycle and stays 1. Issuing continues. rsp_valid with outstanding=0 -> err=1 and outstanding stays 0.
- Assert rst_n=0 asynchronously mid-PEND with outstanding=3 -> req, outstanding and err go to 0 without waiting for a clock edge. After release, the first request is ch 0, key 0.

Source files
------------

// File: rtl/req_key_gen.sv
// Multi-channel request generator: per-channel keys advance on accepted handshakes,
// round-robin channel pick, and an in-order FIFO that checks returning responses.
module req_key_gen #(
    parameter  int NUM_CH = 4,
    parameter  int KEY_W  = 4,
    parameter  int DEPTH  = 4,
    localparam int CH_W   = $clog2(NUM_CH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              req,
    output logic [CH_W-1:0]   req_ch,
    output logic [KEY_W-1:0]  req_key,
    input  logic              ack,
    input  logic              rsp_valid,
    input  logic [CH_W-1:0]   rsp_ch,
    input  logic [KEY_W-1:0]  rsp_key,
    output logic [CNT_W-1:0]  outstanding,
    output logic              err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = CH_W + KEY_W;

    typedef enum logic {IDLE, PEND} state_t;

    state_t             state, state_nxt;
    logic [KEY_W-1:0]   keys [NUM_CH];
    logic [ENT_W-1:0]   mem  [DEPTH];
    logic [CH_W-1:0]    rr_ptr, rr_eff, win_ch, idx;
    logic [KEY_W-1:0]   win_key;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               fire, pop, eligible, launch, win_found, rsp_bad;

    function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fire      = req && ack;
    assign pop       = rsp_valid && (count != '0);
    assign count_nxt = count + CNT_W'(fire) - CNT_W'(pop);
    assign rsp_bad   = rsp_valid && ((count == '0) || ({rsp_ch, rsp_key} != mem[rd_ptr]));

    // On the ack cycle the pointer has effectively moved past the accepted channel already.
    assign rr_eff = fire ? ch_inc(req_ch) : rr_ptr;

    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(rr_eff) + i) % NUM_CH);
            if (!win_found && ch_en[idx]) begin
                win_found = 1'b1;
                win_ch    = idx;
            end
        end
    end

    // Re-picking the channel just accepted must see its key already incremented.
    always_comb begin
        win_key = keys[win_ch];
        if (fire && (win_ch == req_ch))
            win_key = keys[win_ch] + 1'b1;
    end

    assign eligible = win_found && (count_nxt < CNT_W'(DEPTH));
    assign launch   = ((state == IDLE) || fire) && eligible;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = PEND;
            PEND:    if (fire)   state_nxt = launch ? PEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req = (state == PEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ch  <= '0;
            req_key <= '0;
            rr_ptr  <= '0;
            for (int c = 0; c < NUM_CH; c++) keys[c] <= '0;
        end else begin
            if (fire) begin
                keys[req_ch] <= keys[req_ch] + 1'b1;
                rr_ptr       <= ch_inc(req_ch);
            end
            if (launch) begin
                req_ch  <= win_ch;
                req_key <= win_key;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (fire) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
            if (rsp_bad) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) mem[wr_ptr] <= {req_ch, req_key};
    end

    assign outstanding = count;

endmodule

// File: tb/tb_req_key_gen.sv
// Directed bench for req_key_gen: issue ordering, hold-off, key wrap, response
// checking and asynchronous reset, all against hand-computed expectations.
module tb_req_key_gen;

    logic       clk;
    logic       rst_n;
    logic [3:0] ch_en;
    logic       req;
    logic [1:0] req_ch;
    logic [3:0] req_key;
    logic       ack;
    logic       rsp_valid;
    logic [1:0] rsp_ch;
    logic [3:0] rsp_key;
    logic [2:0] outstanding;
    logic       err;

    int errors = 0;
    int checks = 0;

    logic       prev_v;
    logic [1:0] prev_ch;
    logic [3:0] prev_key;

    req_key_gen #(.NUM_CH(4), .KEY_W(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_en      (ch_en),
        .req        (req),
        .req_ch     (req_ch),
        .req_key    (req_key),
        .ack        (ack),
        .rsp_valid  (rsp_valid),
        .rsp_ch     (rsp_ch),
        .rsp_key    (rsp_key),
        .outstanding(outstanding),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ch_en     = 4'b0000;
        ack       = 1'b0;
        rsp_valid = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
    endtask

    // Present the previously shown request as a response and remember the current one.
    task automatic echo_step();
        rsp_valid = prev_v;
        rsp_ch    = prev_ch;
        rsp_key   = prev_key;
        prev_v    = req;
        prev_ch   = req_ch;
        prev_key  = req_key;
    endtask

    initial begin
        rst_n = 1'b0; ch_en = '0; ack = 1'b0;
        rsp_valid = 1'b0; rsp_ch = '0; rsp_key = '0;
        prev_v = 1'b0; prev_ch = '0; prev_key = '0;
        tick(); tick();
        check("rst_req", req, 0);
        check("rst_ch", req_ch, 0);
        check("rst_key", req_key, 0);
        check("rst_out", outstanding, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // single channel, ack always high, no responses
        ch_en = 4'b0001; ack = 1'b1;
        check("t1_pre_req", req, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t1_req", req, 1);
            check("t1_ch", req_ch, 0);
            check("t1_key", req_key, k);
            tick();
        end
        check("t1_drop", req, 0);
        check("t1_full", outstanding, 4);
        ch_en = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            rsp_valid = 1'b1; rsp_ch = 2'd0; rsp_key = 4'(k);
            tick();
        end
        rsp_valid = 1'b0;
        check("t1_drain", outstanding, 0);
        check("t1_err", err, 0);

        // round robin across all channels with echoed responses
        do_reset();
        ch_en = 4'b1111; ack = 1'b1; prev_v = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("t2_ch", req_ch, i % 4);
            check("t2_key", req_key, i / 4);
            check("t2_out", outstanding, (i == 0) ? 0 : 1);
            echo_step();
            if (i == 7) ch_en = 4'b0000;
            tick();
        end
        echo_step();
        tick();
        rsp_valid = 1'b0;
        check("t2_req", req, 0);
        check("t2_out_end", outstanding, 0);
        check("t2_err", err, 0);

        // pending request held while ack is low and enables change
        do_reset();
        ch_en = 4'b0100; ack = 1'b0;
        tick();
        ch_en = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_req", req, 1);
            check("t3_hold_ch", req_ch, 2);
            check("t3_hold_key", req_key, 0);
        end
        ack = 1'b1;
        tick();
        check("t3_next_req", req, 1);
        check("t3_next_ch", req_ch, 0);
        check("t3_next_key", req_key, 0);
        ch_en = 4'b0000;
        tick();
        ack = 1'b0;
        check("t3_idle", req, 0);
        check("t3_out", outstanding, 2);

        // key wrap on one channel with echoed responses
        do_reset();
        ch_en = 4'b0010; ack = 1'b1; prev_v = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            check("t4_ch", req_ch, 1);
            check("t4_key", req_key, i % 16);
            echo_step();
            if (i == 16) ch_en = 4'b0000;
            tick();
        end
        echo_step();
        tick();
        rsp_valid = 1'b0;
        check("t4_req", req, 0);
        check("t4_out", outstanding, 0);
        check("t4_err", err, 0);

        // response mismatch; channel 1 key is now 1
        ch_en = 4'b0010;
        tick();
        check("t5_key", req_key, 1);
        ch_en = 4'b0000;
        tick();
        rsp_valid = 1'b1; rsp_ch = 2'd1; rsp_key = 4'd2;
        tick();
        rsp_valid = 1'b0;
        check("t5_err", err, 1);
        check("t5_out", outstanding, 0);
        ch_en = 4'b0010;
        tick();
        check("t5_cont_req", req, 1);
        check("t5_cont_key", req_key, 2);
        ch_en = 4'b0000;
        tick();
        rsp_valid = 1'b1; rsp_ch = 2'd1; rsp_key = 4'd2;
        tick();
        rsp_valid = 1'b0;
        check("t5_sticky", err, 1);
        check("t5_out2", outstanding, 0);
        do_reset();
        check("t5_rst_err", err, 0);
        rsp_valid = 1'b1; rsp_ch = 2'd0; rsp_key = 4'd0;
        tick();
        rsp_valid = 1'b0;
        check("t5_empty_err", err, 1);
        check("t5_empty_out", outstanding, 0);

        // asynchronous reset while a request is pending
        do_reset();
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        ch_en = 4'b0001; ack = 1'b1;
        tick(); tick(); tick(); tick();
        ack = 1'b0;
        check("t6_pre_req", req, 1);
        check("t6_pre_key", req_key, 3);
        check("t6_pre_out", outstanding, 3);
        check("t6_pre_err", err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_req", req, 0);
        check("t6_async_out", outstanding, 0);
        check("t6_async_err", err, 0);
        check("t6_async_key", req_key, 0);
        #1;
        rst_n = 1'b1;
        tick();
        check("t6_first_req", req, 1);
        check("t6_first_ch", req_ch, 0);
        check("t6_first_key", req_key, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
